seg_scan_driver: RTL and testbench

- Parametrised time-multiplexed seven-segment scan driver. Successor to the fixed 4-digit per-clock mux.
- Adds a configurable digit count and a refresh prescaler.
- Adds an anti-ghosting blank interval, per-digit enable, 16-level brightness and tear-free frame-latched inputs.
- Sits between the segment encoders and the board anode/cathode pins.

---
 rtl/seg_scan_driver_pkg.sv | 17 +
 rtl/seg_scan_driver_if.sv | 28 ++
 rtl/seg_scan_driver_scan_prescaler.sv | 45 ++++
 rtl/seg_scan_driver.sv | 127 ++++++++++++
 tb/tb_seg_scan_driver.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg_pkg;

  localparam int unsigned BRIGHT_W = 4;
  localparam int unsigned POL_W    = 16;

  // Counter width for a range of n values (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Map a "1 = active" vector onto pin polarity.
  function automatic logic [POL_W-1:0] to_pin(input logic [POL_W-1:0] v, input bit active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Encoder-side inputs and pin-side outputs of the scan driver.
interface seg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_W      = 7
);
  import seg_pkg::*;

  localparam int unsigned DW = cnt_w(NUM_DIGITS);

  logic [NUM_DIGITS*SEG_W-1:0] digits;
  logic [NUM_DIGITS-1:0]       digit_en;
  logic [BRIGHT_W-1:0]         brightness;
  logic [NUM_DIGITS-1:0]       an;
  logic [SEG_W-1:0]            sseg;
  logic [DW-1:0]               cur_digit;
  logic                        frame_start;

  modport master (
    output digits, digit_en, brightness,
    input  an, sseg, cur_digit, frame_start
  );

  modport slave (
    input  digits, digit_en, brightness,
    output an, sseg, cur_digit, frame_start
  );

endinterface

// File: rtl/seg_scan_driver_scan_prescaler.sv
// Slot tick and digit counters; exposes next-state values and slot/frame strobes.
module scan_prescaler
  import seg_pkg::*;
#(
  parameter  int unsigned PRESCALE   = 100000,
  parameter  int unsigned NUM_DIGITS = 4,
  localparam int unsigned TW         = cnt_w(PRESCALE),
  localparam int unsigned DW         = cnt_w(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [TW-1:0] tick_nxt_c,
  output logic [DW-1:0] digit_nxt_c,
  output logic          slot_start_c,
  output logic          frame_start_c
);

  logic [TW-1:0] tick_q;
  logic [DW-1:0] digit_q;

  // Next counter values; digit advances when tick wraps.
  always_comb begin
    tick_nxt_c   = tick_q + TW'(1);
    digit_nxt_c  = digit_q;
    slot_start_c = 1'b0;
    if (tick_q == TW'(PRESCALE - 1)) begin
      tick_nxt_c   = '0;
      slot_start_c = 1'b1;
      digit_nxt_c  = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + DW'(1);
    end
    frame_start_c = slot_start_c && (digit_nxt_c == '0);
  end

  // Reset parks at the last tick of the last digit so the first edge starts a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q  <= TW'(PRESCALE - 1);
      digit_q <= DW'(NUM_DIGITS - 1);
    end else begin
      tick_q  <= tick_nxt_c;
      digit_q <= digit_nxt_c;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with blanking, per-digit enable,
// 16-level brightness and frame-latched inputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS     = 4,
  parameter  int unsigned SEG_W          = 7,
  parameter  int unsigned PRESCALE       = 100000,
  parameter  int unsigned BLANK_CYCLES   = 16,
  parameter  bit          AN_ACTIVE_LOW  = 1'b1,
  parameter  bit          SEG_ACTIVE_LOW = 1'b1,
  localparam int unsigned TW             = cnt_w(PRESCALE),
  localparam int unsigned DW             = cnt_w(NUM_DIGITS),
  localparam int unsigned CW             = cnt_w(PRESCALE) + 1,
  localparam int unsigned STEP           = (PRESCALE - BLANK_CYCLES) / 16
) (
  input logic              clk,
  input logic              reset,
  seg_scan_driver_if.slave bus
);

  localparam logic [1:0] ST_BLANK = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_DARK  = 2'd2;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW  ? '1 : '0;
  localparam logic [SEG_W-1:0]      SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;

  logic [TW-1:0] tick_nxt;
  logic [DW-1:0] digit_nxt;
  logic          slot_start;
  logic          frame_start_c;

  scan_prescaler #(
    .PRESCALE   (PRESCALE),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_prescaler (
    .clk           (clk),
    .reset         (reset),
    .tick_nxt_c    (tick_nxt),
    .digit_nxt_c   (digit_nxt),
    .slot_start_c  (slot_start),
    .frame_start_c (frame_start_c)
  );

  logic [NUM_DIGITS*SEG_W-1:0] sh_dig_q,    sh_dig_nxt;
  logic [NUM_DIGITS-1:0]       sh_en_q,     sh_en_nxt;
  logic [BRIGHT_W-1:0]         sh_bright_q, sh_bright_nxt;
  logic [1:0]                  state_q,     state_d;
  logic [NUM_DIGITS-1:0]       an_q,        an_d;
  logic [SEG_W-1:0]            sseg_q,      sseg_d;
  logic                        frame_q;
  logic [DW-1:0]               cur_q;

  // Shadow copy of the inputs, refreshed only at the frame boundary.
  always_comb begin
    sh_dig_nxt    = sh_dig_q;
    sh_en_nxt     = sh_en_q;
    sh_bright_nxt = sh_bright_q;
    if (frame_start_c) begin
      sh_dig_nxt    = bus.digits;
      sh_en_nxt     = bus.digit_en;
      sh_bright_nxt = bus.brightness;
    end
  end

  logic [CW-1:0]         tick_ext;
  logic [CW-1:0]         on_end;
  logic                  en_ok;
  logic [SEG_W-1:0]      pattern;
  logic [NUM_DIGITS-1:0] onehot;

  // Slot FSM and pin values, evaluated on next-state counters so pins move with tick.
  always_comb begin
    state_d  = state_q;
    an_d     = AN_OFF;
    sseg_d   = SEG_OFF;
    tick_ext = CW'(tick_nxt);
    on_end   = CW'(BLANK_CYCLES) + CW'(STEP) * (CW'(sh_bright_nxt) + CW'(1));
    en_ok    = sh_en_nxt[digit_nxt];
    pattern  = sh_dig_nxt[32'(digit_nxt) * SEG_W +: SEG_W];
    onehot   = NUM_DIGITS'(1) << digit_nxt;

    case (state_q)
      ST_BLANK: if (en_ok && tick_ext >= CW'(BLANK_CYCLES)) state_d = ST_ON;
      ST_ON:    if (tick_ext >= on_end) state_d = ST_DARK;
      default:  state_d = ST_DARK;
    endcase

    if (slot_start) begin
      state_d = (en_ok && BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
    end

    if (state_d == ST_ON) begin
      an_d   = NUM_DIGITS'(to_pin(POL_W'(onehot), AN_ACTIVE_LOW));
      sseg_d = SEG_W'(to_pin(POL_W'(pattern), SEG_ACTIVE_LOW));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_BLANK;
      sh_dig_q    <= '0;
      sh_en_q     <= '0;
      sh_bright_q <= '0;
      an_q        <= AN_OFF;
      sseg_q      <= SEG_OFF;
      frame_q     <= 1'b0;
      cur_q       <= '0;
    end else begin
      state_q     <= state_d;
      sh_dig_q    <= sh_dig_nxt;
      sh_en_q     <= sh_en_nxt;
      sh_bright_q <= sh_bright_nxt;
      an_q        <= an_d;
      sseg_q      <= sseg_d;
      frame_q     <= frame_start_c;
      cur_q       <= digit_nxt;
    end
  end

  assign bus.an          = an_q;
  assign bus.sseg        = sseg_q;
  assign bus.frame_start = frame_q;
  assign bus.cur_digit   = cur_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4-digit and 8-digit configurations, active-low pins.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;

  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(4), .SEG_W(7)) bus_a ();
  seg_scan_driver_if #(.NUM_DIGITS(8), .SEG_W(7)) bus_b ();

  seg_scan_driver #(
    .NUM_DIGITS(4), .SEG_W(7), .PRESCALE(20), .BLANK_CYCLES(4),
    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  seg_scan_driver #(
    .NUM_DIGITS(8), .SEG_W(7), .PRESCALE(36), .BLANK_CYCLES(4),
    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  localparam logic [27:0] DG0 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [27:0] DG1 = {7'h4F, 7'h5B, 7'h06, 7'h06};

  function automatic logic [6:0] pat4(input logic [27:0] dg, input int d);
    logic [27:0] v;
    v = dg;
    return v[d*7 +: 7];
  endfunction

  // Check ncyc cycles of dut_a from a frame start; optionally change digits after cycle chg_at.
  task automatic run_a(input logic [3:0] b, input logic [3:0] en, input logic [27:0] dg,
                       input int ncyc, input int chg_at, input logic [27:0] chg_dg);
    for (int c = 0; c < ncyc; c++) begin
      int t;
      int d;
      logic lit;
      logic [3:0] e_an;
      logic [6:0] e_sg;
      @(posedge clk);
      #1;
      t    = c % 20;
      d    = (c / 20) % 4;
      lit  = en[d] && t >= 4 && t < 5 + int'(b);
      e_an = 4'b0001 << d;
      e_an = lit ? ~e_an : 4'hF;
      e_sg = pat4(dg, d);
      e_sg = lit ? ~e_sg : 7'h7F;
      chk("a_an",   32'(bus_a.an),          32'(e_an));
      chk("a_sseg", 32'(bus_a.sseg),        32'(e_sg));
      chk("a_fs",   32'(bus_a.frame_start), 32'(c == 0));
      chk("a_cur",  32'(bus_a.cur_digit),   32'(d));
      if (c == chg_at) bus_a.digits = chg_dg;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] dg_b;
    int last_fs;
    int n_fs;

    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.brightness = 4'd15;
    bus_a.digit_en   = 4'hF;
    bus_a.digits     = DG0;
    for (int i = 0; i < 8; i++) dg_b[i*7 +: 7] = 7'(i * 9 + 3);
    bus_b.brightness = 4'd6;
    bus_b.digit_en   = 8'hFF;
    bus_b.digits     = dg_b;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",   32'(bus_a.an),          32'h0000_000F);
    chk("rst_sseg", 32'(bus_a.sseg),        32'h0000_007F);
    chk("rst_fs",   32'(bus_a.frame_start), 32'h0);
    chk("rst_cur",  32'(bus_a.cur_digit),   32'h0);
    chk("rst_b_an", 32'(bus_b.an),          32'h0000_00FF);

    reset_a = 1'b0;
    run_a(4'd15, 4'hF, DG0, 80, -1, DG0);
    bus_a.brightness = 4'd3;
    run_a(4'd3, 4'hF, DG0, 80, -1, DG0);
    bus_a.brightness = 4'd15;
    bus_a.digit_en   = 4'b1011;
    run_a(4'd15, 4'b1011, DG0, 80, -1, DG0);
    bus_a.digit_en = 4'hF;
    run_a(4'd15, 4'hF, DG0, 80, 30, DG1);
    run_a(4'd15, 4'hF, DG1, 80, -1, DG1);

    // Stop at tick 10 of digit 2, then reset between edges.
    run_a(4'd15, 4'hF, DG1, 51, -1, DG1);
    reset_a = 1'b1;
    #1;
    chk("mid_rst_an",   32'(bus_a.an),          32'h0000_000F);
    chk("mid_rst_sseg", 32'(bus_a.sseg),        32'h0000_007F);
    chk("mid_rst_fs",   32'(bus_a.frame_start), 32'h0);
    chk("mid_rst_cur",  32'(bus_a.cur_digit),   32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold", 32'(bus_a.an), 32'h0000_000F);
    reset_a = 1'b0;
    run_a(4'd15, 4'hF, DG1, 80, -1, DG1);

    // 8-digit wrap, STEP=2 so brightness 6 lights ticks 4..17.
    reset_b = 1'b0;
    last_fs = -1;
    n_fs    = 0;
    for (int c = 0; c < 577; c++) begin
      int t;
      int d;
      logic lit;
      logic [7:0] e_an;
      logic [6:0] e_sg;
      @(posedge clk);
      #1;
      t    = c % 36;
      d    = (c / 36) % 8;
      lit  = t >= 4 && t < 18;
      e_an = 8'h01 << d;
      e_an = lit ? ~e_an : 8'hFF;
      e_sg = dg_b[d*7 +: 7];
      e_sg = lit ? ~e_sg : 7'h7F;
      chk("b_an",      32'(bus_b.an),        32'(e_an));
      chk("b_sseg",    32'(bus_b.sseg),      32'(e_sg));
      chk("b_cur",     32'(bus_b.cur_digit), 32'(d));
      chk("b_one_low", 32'($countones(~bus_b.an) <= 1), 32'h1);
      if (bus_b.frame_start) begin
        n_fs++;
        if (last_fs >= 0) chk("b_period", 32'(c - last_fs), 32'd288);
        else chk("b_first_fs", 32'(c), 32'd0);
        last_fs = c;
      end
    end
    chk("b_frames", 32'(n_fs), 32'd3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
